counter_bcd_7seg: RTL and testbench

Sits directly downstream of the push-button debouncers. Consumes two debounced level signals (count up, count down) and turns each rising edge into exactly one count step. It holds a 4-digit BCD counter (0000-9999) and drives a time-multiplexed, active-low 4-digit 7-segment display. Display timing comes from a free-running refresh counter.

---
 rtl/counter_bcd_7seg.sv | 124 ++++++++++++
 tb/tb_counter_bcd_7seg.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_bcd_7seg.sv
// counter_bcd_7seg
//   Four-digit BCD up/down counter driven by debounced push-button levels,
//   with a time-multiplexed, active-low 4-digit 7-segment display.
//
// Ports:
//   clk      system clock, all state changes on its rising edge
//   reset    asynchronous active-low reset
//   db_up    debounced level from the up button (rising edge = +1)
//   db_down  debounced level from the down button (rising edge = -1)
//   count    current value, BCD: [15:12] thousands .. [3:0] ones
//   an       digit anodes, active-low, an[0] = ones digit
//   seg      segments a..g on seg[6:0], active-low
module counter_bcd_7seg #(
    parameter int unsigned REFRESH_BITS = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        db_up,
    input  logic        db_down,
    output logic [15:0] count,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    logic                    prev_up;
    logic                    prev_down;
    logic                    up_tick;
    logic                    down_tick;
    logic [15:0]             count_next;
    logic [REFRESH_BITS-1:0] refresh;
    logic [1:0]              sel;
    logic [3:0]              digit;
    logic [3:0]              cur;
    logic                    chain;
    logic [3:0]              an_next;
    logic [6:0]              seg_next;

    // prev_* reset to 1 so a level already high at reset release is not a step.
    assign up_tick   = db_up & ~prev_up;
    assign down_tick = db_down & ~prev_down;
    assign sel       = refresh[REFRESH_BITS-1 -: 2];

    function automatic logic [6:0] decode(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = 7'b0000001;
            4'd1:    pattern = 7'b1001111;
            4'd2:    pattern = 7'b0010010;
            4'd3:    pattern = 7'b0000110;
            4'd4:    pattern = 7'b1001100;
            4'd5:    pattern = 7'b0100100;
            4'd6:    pattern = 7'b0100000;
            4'd7:    pattern = 7'b0001111;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0000100;
            default: pattern = 7'b1111111;
        endcase
        return pattern;
    endfunction

    // Ripple carry/borrow through the digits; chain stays set while every
    // lower digit wrapped (9->0 on increment, 0->9 on decrement).
    always_comb begin
        count_next = count;
        chain      = 1'b1;
        cur        = '0;
        if (up_tick && !down_tick) begin
            for (int unsigned i = 0; i < 4; i++) begin
                cur = count[4*i +: 4];
                if (chain) begin
                    if (cur == 4'd9) begin
                        cur = 4'd0;
                    end else begin
                        cur   = cur + 4'd1;
                        chain = 1'b0;
                    end
                end
                count_next[4*i +: 4] = cur;
            end
        end else if (down_tick && !up_tick) begin
            for (int unsigned i = 0; i < 4; i++) begin
                cur = count[4*i +: 4];
                if (chain) begin
                    if (cur == 4'd0) begin
                        cur = 4'd9;
                    end else begin
                        cur   = cur - 4'd1;
                        chain = 1'b0;
                    end
                end
                count_next[4*i +: 4] = cur;
            end
        end
    end

    always_comb begin
        case (sel)
            2'd0:    begin an_next = 4'b1110; digit = count[3:0];   end
            2'd1:    begin an_next = 4'b1101; digit = count[7:4];   end
            2'd2:    begin an_next = 4'b1011; digit = count[11:8];  end
            default: begin an_next = 4'b0111; digit = count[15:12]; end
        endcase
        seg_next = decode(digit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_up   <= 1'b1;
            prev_down <= 1'b1;
            count     <= '0;
            refresh   <= '0;
            an        <= '1;
            seg       <= '1;
        end else begin
            prev_up   <= db_up;
            prev_down <= db_down;
            count     <= count_next;
            refresh   <= refresh + REFRESH_BITS'(1);
            an        <= an_next;
            seg       <= seg_next;
        end
    end

endmodule

// File: tb/tb_counter_bcd_7seg.sv
// tb_counter_bcd_7seg
//   Self-checking bench for counter_bcd_7seg with a short refresh counter.
//   The reference model keeps the count as a plain integer 0..9999 and the
//   refresh position as an integer, deriving digits with division.
module tb_counter_bcd_7seg;

    localparam int RB = 4;

    logic        clk;
    logic        reset;
    logic        db_up;
    logic        db_down;
    logic [15:0] count;
    logic [3:0]  an;
    logic [6:0]  seg;

    int checks = 0;
    int errors = 0;

    counter_bcd_7seg #(.REFRESH_BITS(RB)) dut (
        .clk     (clk),
        .reset   (reset),
        .db_up   (db_up),
        .db_down (db_down),
        .count   (count),
        .an      (an),
        .seg     (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100};
    int         pow10 [4]    = '{1, 10, 100, 1000};

    int         m_val;
    bit         m_pu;
    bit         m_pd;
    int         m_ref;
    logic [3:0] m_an;
    logic [6:0] m_seg;

    always @(posedge clk or negedge reset) begin
        int  idx;
        bit  ut;
        bit  dt;
        if (!reset) begin
            m_val = 0;
            m_pu  = 1'b1;
            m_pd  = 1'b1;
            m_ref = 0;
            m_an  = 4'b1111;
            m_seg = 7'b1111111;
        end else begin
            idx   = m_ref / (1 << (RB - 2));
            m_an  = ~(4'b0001 << idx);
            m_seg = seg_tab[(m_val / pow10[idx]) % 10];
            ut    = db_up && !m_pu;
            dt    = db_down && !m_pd;
            if (ut && !dt)      m_val = (m_val + 1) % 10000;
            else if (dt && !ut) m_val = (m_val + 9999) % 10000;
            m_pu  = db_up;
            m_pd  = db_down;
            m_ref = (m_ref + 1) % (1 << RB);
        end
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b0;
        db_up   = 1'b0;
        db_down = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse(input bit up, input bit dn, input int hi, input int lo);
        db_up   = up;
        db_down = dn;
        repeat (hi) @(negedge clk);
        db_up   = 1'b0;
        db_down = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset   = 1'b0;
        db_up   = 1'b0;
        db_down = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (count !== 16'h0000) begin
            errors++; $display("FAIL reset_count: got %h expected 0000", count);
        end
        checks++;
        if (an !== 4'b1111) begin
            errors++; $display("FAIL reset_an: got %b expected 1111", an);
        end
        checks++;
        if (seg !== 7'b1111111) begin
            errors++; $display("FAIL reset_seg: got %b expected 1111111", seg);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (an !== 4'b1110 || seg !== 7'b0000001) begin
            errors++; $display("FAIL first_scan: got an=%b seg=%b expected an=1110 seg=0000001", an, seg);
        end
    endtask

    task automatic test_held_at_release();
        @(negedge clk);
        reset   = 1'b0;
        db_up   = 1'b1;
        db_down = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (count !== 16'h0000) begin
            errors++; $display("FAIL held_at_release: got %h expected 0000", count);
        end
        db_up = 1'b0;
        repeat (3) @(negedge clk);
        db_up = 1'b1;
        @(negedge clk);
        checks++;
        if (count !== 16'h0001) begin
            errors++; $display("FAIL first_step_latency: got %h expected 0001", count);
        end
        repeat (49) @(negedge clk);
        checks++;
        if (count !== 16'h0001) begin
            errors++; $display("FAIL held_no_repeat: got %h expected 0001", count);
        end
        db_up = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_up_pulses();
        do_reset();
        for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0, 3, 1);
        checks++;
        if (count !== 16'h0010 || count !== to_bcd(m_val)) begin
            errors++; $display("FAIL ten_up: got %h expected 0010 (model %h)", count, to_bcd(m_val));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        pulse(1'b0, 1'b1, 3, 1);
        checks++;
        if (count !== 16'h9999) begin
            errors++; $display("FAIL wrap_down_0000: got %h expected 9999", count);
        end
        pulse(1'b1, 1'b0, 3, 1);
        checks++;
        if (count !== 16'h0000) begin
            errors++; $display("FAIL wrap_up_9999: got %h expected 0000", count);
        end
        pulse(1'b0, 1'b1, 3, 1);
        pulse(1'b0, 1'b1, 3, 1);
        checks++;
        if (count !== 16'h9998) begin
            errors++; $display("FAIL down_9999: got %h expected 9998", count);
        end
    endtask

    task automatic test_borrow();
        do_reset();
        for (int i = 0; i < 100; i++) pulse(1'b1, 1'b0, 1, 1);
        checks++;
        if (count !== 16'h0100) begin
            errors++; $display("FAIL up_to_0100: got %h expected 0100", count);
        end
        pulse(1'b0, 1'b1, 3, 1);
        checks++;
        if (count !== 16'h0099) begin
            errors++; $display("FAIL borrow_0100: got %h expected 0099", count);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 42; i++) pulse(1'b1, 1'b0, 1, 1);
        checks++;
        if (count !== 16'h0042) begin
            errors++; $display("FAIL up_to_0042: got %h expected 0042", count);
        end
        pulse(1'b1, 1'b1, 3, 1);
        checks++;
        if (count !== 16'h0042) begin
            errors++; $display("FAIL both_ticks: got %h expected 0042", count);
        end
        pulse(1'b0, 1'b1, 3, 1);
        checks++;
        if (count !== 16'h0041) begin
            errors++; $display("FAIL down_after_both: got %h expected 0041", count);
        end
    endtask

    task automatic test_display();
        logic [3:0] scan_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] scan_seg [4] = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
        bit aligned = 1'b0;
        do_reset();
        for (int i = 0; i < 1234; i++) pulse(1'b1, 1'b0, 1, 1);
        checks++;
        if (count !== 16'h1234) begin
            errors++; $display("FAIL up_to_1234: got %h expected 1234", count);
        end
        for (int i = 0; i < 40; i++) begin
            if (m_ref == 1) begin
                aligned = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!aligned) begin
            errors++; $display("FAIL scan_align: got no scan start expected one within 40 cycles");
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (an !== scan_an[k / 4] || seg !== scan_seg[k / 4]) begin
                errors++;
                $display("FAIL scan_%0d: got an=%b seg=%b expected an=%b seg=%b",
                         k, an, seg, scan_an[k / 4], scan_seg[k / 4]);
            end
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (an !== 4'b1111 || count !== 16'h0000 || seg !== 7'b1111111) begin
            errors++;
            $display("FAIL async_reset: got an=%b count=%h seg=%b expected an=1111 count=0000 seg=1111111",
                     an, count, seg);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) db_up = ~db_up;
            if ($urandom_range(0, 3) == 0) db_down = ~db_down;
            @(negedge clk);
            checks++;
            if (count !== to_bcd(m_val)) begin
                errors++; $display("FAIL rand_count_%0d: got %h expected %h", i, count, to_bcd(m_val));
            end
            checks++;
            if (an !== m_an || seg !== m_seg) begin
                errors++;
                $display("FAIL rand_display_%0d: got an=%b seg=%b expected an=%b seg=%b",
                         i, an, seg, m_an, m_seg);
            end
        end
        db_up   = 1'b0;
        db_down = 1'b0;
        for (int i = 0; i < 1200; i++) pulse(1'b1, 1'b0, 1, 1);
        checks++;
        if (count !== to_bcd(m_val)) begin
            errors++; $display("FAIL rand_tail: got %h expected %h", count, to_bcd(m_val));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish before 2 ms");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_held_at_release();
        test_up_pulses();
        test_wrap();
        test_borrow();
        test_simultaneous();
        test_display();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
